// File: rtl/adc_nch_tap_cal.sv
// adc_nch_tap_cal: per-channel IDELAY tap sweep, eye centring, lock report and lock-masked data capture
module adc_nch_tap_cal #(
  parameter int N_CH = 4,
  parameter int DATA_W = 16,
  parameter int TAP_W = 5,
  parameter int SETTLE = 8,
  parameter int SAMPLES = 64,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 16'hA55A,
  parameter int MIN_EYE = 4
) (
  input  logic                     CLK_IN,
  input  logic                     IO_RESET,
  input  logic                     CAL_START,
  input  logic [N_CH*DATA_W-1:0]   ADC_DATA_IN,
  output logic [N_CH*TAP_W-1:0]    DELAY_TAP_OUT,
  output logic [N_CH-1:0]          DELAY_LD,
  output logic                     CAL_BUSY,
  output logic                     CAL_DONE,
  output logic [N_CH-1:0]          CH_LOCK,
  output logic [N_CH*DATA_W-1:0]   CH_DATA_OUT,
  output logic                     CH_DATA_VALID
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SETTLE = 3'd2, S_SAMPLE = 3'd3,
                         S_EVAL = 3'd4, S_CENTER = 3'd5, S_NEXT = 3'd6, S_DONE = 3'd7;
  localparam int CW = $clog2(SETTLE > SAMPLES ? SETTLE : SAMPLES) + 1;
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam logic [TAP_W-1:0] TAP_MAX = '1;
  logic [2:0] state, state_n;
  logic [CH_W-1:0] ch;
  logic [TAP_W-1:0] tap, run_start, best_start, cur_start, tap_final;
  logic [TAP_W:0] run_len, best_len, cur_len;
  logic [CW-1:0] cnt;
  logic fail, calibrated, closing, eye_ok;
  logic [TAP_W-1:0] taps [N_CH];
  logic [DATA_W-1:0] word;
  logic [N_CH*DATA_W-1:0] lock_mask;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = CAL_START ? S_LOAD : S_IDLE;
      S_LOAD:   state_n = S_SETTLE;
      S_SETTLE: state_n = cnt == CW'(SETTLE - 1) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: state_n = cnt == CW'(SAMPLES - 1) ? S_EVAL : S_SAMPLE;
      S_EVAL:   state_n = tap == TAP_MAX ? S_CENTER : S_LOAD;
      S_CENTER: state_n = S_NEXT;
      S_NEXT:   state_n = ch == CH_W'(N_CH - 1) ? S_DONE : S_LOAD;
      default:  state_n = S_IDLE;
    endcase
  end
  assign word = ADC_DATA_IN[ch*DATA_W +: DATA_W];
  assign cur_len = run_len + {{TAP_W{1'b0}}, ~fail};
  assign cur_start = run_len == '0 ? tap : run_start;
  assign closing = fail | (tap == TAP_MAX);
  assign eye_ok = best_len >= (TAP_W+1)'(MIN_EYE);
  assign tap_final = eye_ok ? best_start + TAP_W'((best_len - 1'b1) >> 1) : '0;
  assign CAL_BUSY = state != S_IDLE && state != S_DONE;
  assign CAL_DONE = state == S_DONE;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign DELAY_LD[c] = (state == S_LOAD || state == S_CENTER) && ch == CH_W'(c);
    assign DELAY_TAP_OUT[c*TAP_W +: TAP_W] = !DELAY_LD[c] ? taps[c] : state == S_LOAD ? tap : tap_final;
    assign lock_mask[c*DATA_W +: DATA_W] = {DATA_W{CH_LOCK[c]}};
  end
  always_ff @(posedge CLK_IN) begin
    if (IO_RESET) begin
      state <= S_IDLE;
      ch <= '0;
      tap <= '0;
      cnt <= '0;
      fail <= 1'b0;
      run_start <= '0;
      run_len <= '0;
      best_start <= '0;
      best_len <= '0;
      calibrated <= 1'b0;
      CH_LOCK <= '0;
      CH_DATA_OUT <= '0;
      CH_DATA_VALID <= 1'b0;
      for (int i = 0; i < N_CH; i++) taps[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      CH_DATA_OUT <= ADC_DATA_IN & lock_mask;
      CH_DATA_VALID <= (calibrated | CAL_DONE) & (state_n == S_IDLE);
      if (state == S_IDLE && CAL_START) begin
        ch <= '0;
        tap <= '0;
        run_start <= '0;
        run_len <= '0;
        best_start <= '0;
        best_len <= '0;
        CH_LOCK <= '0;
      end
      if (state == S_LOAD) begin
        taps[ch] <= tap;
        fail <= 1'b0;
      end
      if (state == S_SAMPLE && word != TRAIN_PATTERN) fail <= 1'b1;
      if (state == S_EVAL) begin
        run_start <= cur_start;
        run_len <= closing ? '0 : cur_len;
        tap <= tap + 1'b1;
        if (closing && cur_len > best_len) begin
          best_start <= cur_start;
          best_len <= cur_len;
        end
      end
      if (state == S_CENTER) begin
        taps[ch] <= tap_final;
        CH_LOCK[ch] <= eye_ok;
      end
      if (state == S_NEXT) begin
        ch <= ch + 1'b1;
        tap <= '0;
        run_start <= '0;
        run_len <= '0;
        best_start <= '0;
        best_len <= '0;
      end
      if (state == S_DONE) calibrated <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_nch_tap_cal.sv
// tb_adc_nch_tap_cal: directed self-checking bench with an eye-search model and per-cycle compare
module tb_adc_nch_tap_cal;
  localparam int N = 4, ST = 8, SA = 64;
  localparam int Q = ST + SA + 2, P = 32 * Q + 2, T = N * P;
  localparam logic [15:0] TP = 16'hA55A;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [63:0] adc = '0, fixed_word = '0, last_adc = '0;
  logic [19:0] tap_o;
  logic [3:0] ld, lock;
  logic busy, done, valid;
  logic [63:0] dout;
  adc_nch_tap_cal #(.N_CH(4), .DATA_W(16), .TAP_W(5), .SETTLE(ST), .SAMPLES(SA),
                    .TRAIN_PATTERN(TP), .MIN_EYE(4)) dut (
    .CLK_IN(clk), .IO_RESET(rst), .CAL_START(start), .ADC_DATA_IN(adc),
    .DELAY_TAP_OUT(tap_o), .DELAY_LD(ld), .CAL_BUSY(busy), .CAL_DONE(done),
    .CH_LOCK(lock), .CH_DATA_OUT(dout), .CH_DATA_VALID(valid));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  int mode = 1, gl_tap = -1, k = 0, ld_cnt = 0, at = 0;
  bit active = 0, cal_e = 0, chk_en = 0;
  logic [31:0] pmask [4];
  int cur_tap [4], age [4];
  logic [19:0] exp_tap = '0, pred_tap = '0;
  logic [3:0] exp_lock = '0, pred_lock = '0;
  int cmp_o, cmp_c, cmp_r;
  bit cmp_busy, cmp_done, cmp_ld;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [63:0] lmask(input logic [3:0] l);
    logic [63:0] m;
    for (int c = 0; c < 4; c++) m[c*16 +: 16] = {16{l[c]}};
    return m;
  endfunction
  task automatic predict();
    logic [31:0] e;
    int bs, bl, len;
    for (int c = 0; c < 4; c++) begin
      e = pmask[c];
      if (c == 0 && gl_tap >= 0) e[gl_tap] = 1'b0;
      bs = 0;
      bl = 0;
      for (int s = 0; s < 32; s++)
        if (e[s] && (s == 0 || !e[s-1])) begin
          len = 0;
          while (s + len < 32 && e[s+len]) len++;
          if (len > bl) begin
            bl = len;
            bs = s;
          end
        end
      pred_lock[c] = bl >= 4;
      pred_tap[c*5 +: 5] = bl >= 4 ? 5'(bs + (bl - 1) / 2) : 5'd0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (ld[c]) begin
        cur_tap[c] = int'(tap_o[c*5 +: 5]);
        age[c] = 0;
      end else age[c]++;
    if (mode == 1) adc = {$urandom, $urandom};
    else if (mode == 2) adc = fixed_word;
    else
      for (int c = 0; c < 4; c++)
        adc[c*16 +: 16] = (pmask[c][cur_tap[c]] && !(c == 0 && cur_tap[c] == gl_tap && age[c] == 40)) ? TP : ~TP;
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (active && cyc == k + 1 + T) begin
        exp_tap = pred_tap;
        exp_lock = pred_lock;
      end
      cmp_busy = active && cyc >= k + 1 && cyc <= k + T;
      cmp_done = active && cyc == k + 1 + T;
      chk("busy", 64'(busy), 64'(cmp_busy));
      chk("done", 64'(done), 64'(cmp_done));
      chk("valid", 64'(valid), 64'(cal_e && !(active && cyc >= k + 1 && cyc <= k + 1 + T)));
      if (cmp_busy) begin
        cmp_o = cyc - k - 1;
        cmp_c = cmp_o / P;
        cmp_r = cmp_o % P;
        cmp_ld = (cmp_r < 32 * Q && cmp_r % Q == 0) || cmp_r == 32 * Q;
        chk("ld", 64'(ld), cmp_ld ? 64'(1) << cmp_c : 64'(0));
        if (cmp_ld)
          chk("ld_tap", 64'(tap_o[cmp_c*5 +: 5]), cmp_r < 32 * Q ? 64'(cmp_r / Q) : 64'(pred_tap[cmp_c*5 +: 5]));
        ld_cnt += $countones(ld);
      end else begin
        chk("ld_idle", 64'(ld), 64'(0));
        chk("taps", 64'(tap_o), 64'(exp_tap));
        chk("lock", 64'(lock), 64'(exp_lock));
        chk("dout", dout, last_adc & lmask(exp_lock));
      end
      if (cmp_done) begin
        active = 0;
        cal_e = 1;
      end
    end
    last_adc = adc;
  end
  task automatic do_reset(input int n);
    chk_en = 0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_ld", 64'(ld), 64'(0));
    chk("rst_lock", 64'(lock), 64'(0));
    chk("rst_taps", 64'(tap_o), 64'(0));
    chk("rst_dout", dout, 64'(0));
    rst = 1'b0;
    active = 0;
    cal_e = 0;
    exp_tap = '0;
    exp_lock = '0;
    chk_en = 1;
  endtask
  task automatic cal_start();
    @(posedge clk);
    #1;
    mode = 0;
    predict();
    k = cyc;
    active = 1;
    ld_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    at = -1;
    for (int i = 0; i < T + 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        at = cyc;
        break;
      end
    end
    chk("done_at", 64'(at), 64'(k + 9481));
    mode = 1;
  endtask
  initial begin
    for (int c = 0; c < 4; c++) pmask[c] = 32'h0003FC00;
    do_reset(3);
    repeat (30) @(posedge clk);
    #1;
    chk("valid_no_start", 64'(valid), 64'(0));
    cal_start();
    repeat (500) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("ld_pulses", 64'(ld_cnt), 64'(132));
    chk("taps_c", 64'(tap_o), 64'({5'd13, 5'd13, 5'd13, 5'd13}));
    chk("lock_c", 64'(lock), 64'(4'b1111));
    @(posedge clk);
    #1;
    chk("valid_rise", 64'(valid), 64'(1));
    repeat (40) @(posedge clk);
    pmask[2] = 32'h0;
    gl_tap = 12;
    cal_start();
    chk("recal_valid_fall", 64'(valid), 64'(0));
    @(posedge clk);
    #1;
    chk("recal_lock_clr", 64'(lock), 64'(0));
    wait_done();
    chk("taps_b", 64'(tap_o), 64'({5'd13, 5'd0, 5'd13, 5'd15}));
    chk("lock_b", 64'(lock), 64'(4'b1011));
    mode = 2;
    fixed_word = 64'h1111_2222_3333_4444;
    repeat (2) @(posedge clk);
    #1;
    chk("dout_masked", dout, 64'h1111_0000_3333_4444);
    chk("valid_b", 64'(valid), 64'(1));
    mode = 1;
    repeat (20) @(posedge clk);
    gl_tap = -1;
    pmask[0] = 32'h03F0003C;
    pmask[1] = 32'h00F0003C;
    pmask[2] = 32'hF0000000;
    pmask[3] = 32'h00000380;
    cal_start();
    wait_done();
    chk("taps_a", 64'(tap_o), 64'({5'd0, 5'd29, 5'd3, 5'd22}));
    chk("lock_a", 64'(lock), 64'(4'b0111));
    repeat (20) @(posedge clk);
    for (int c = 0; c < 4; c++) pmask[c] = 32'h0003FC00;
    cal_start();
    while (cyc < k + 3000) @(posedge clk);
    #1;
    do_reset(1);
    mode = 1;
    at = 0;
    for (int i = 0; i < 7000; i++) begin
      @(posedge clk);
      #1;
      if (done) at++;
    end
    chk("no_done_after_rst", 64'(at), 64'(0));
    chk("valid_after_rst", 64'(valid), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
